// File: rtl/div_unit.sv
// Iterative restoring divider for div/divu/rem/remu, one quotient bit per clock.
// Define DIV_UNIT_ZERO_BYPASS_EN to finish divide-by-zero operations in a single cycle.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [4:0]      alusel,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN + 1);

  localparam logic [4:0] OP_DIV  = 5'b11100;
  localparam logic [4:0] OP_DIVU = 5'b01100;
  localparam logic [4:0] OP_REM  = 5'b00100;
  localparam logic [4:0] OP_REMU = 5'b11000;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] q;
  logic [XLEN-1:0] r;
  logic [XLEN-1:0] d;
  logic            op_rem;
  logic            dz;
  logic            neg_q;
  logic            neg_r;

  logic            op_valid;
  logic            op_signed;
  logic            op_is_rem;
  logic            b_zero;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] raw;
  logic [XLEN-1:0] dz_rem;
  logic [XLEN-1:0] fin_val;

  always_comb begin
    op_valid  = 1'b0;
    op_signed = 1'b0;
    op_is_rem = 1'b0;
    unique case (alusel)
      OP_DIV:  begin op_valid = 1'b1; op_signed = 1'b1; end
      OP_DIVU: begin op_valid = 1'b1; end
      OP_REM:  begin op_valid = 1'b1; op_signed = 1'b1; op_is_rem = 1'b1; end
      OP_REMU: begin op_valid = 1'b1; op_is_rem = 1'b1; end
      default: ;
    endcase
  end

  assign b_zero  = (b == '0);
  assign abs_a   = a[XLEN-1] ? ('0 - a) : a;
  assign abs_b   = b[XLEN-1] ? ('0 - b) : b;
  assign shifted = {r, q[XLEN-1]};
  assign diff    = shifted - {1'b0, d};
  assign raw     = op_rem ? r : q;

  // With the bypass the dividend never leaves q; otherwise 32 steps by zero move it into r.
`ifdef DIV_UNIT_ZERO_BYPASS_EN
  assign dz_rem = q;
`else
  assign dz_rem = r;
`endif

  always_comb begin
    fin_val = raw;
    if (dz)
      fin_val = op_rem ? dz_rem : '1;
    else if (op_rem ? neg_r : neg_q)
      fin_val = '0 - raw;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cnt    <= '0;
      q      <= '0;
      r      <= '0;
      d      <= '0;
      op_rem <= 1'b0;
      dz     <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && op_valid) begin
            op_rem <= op_is_rem;
            dz     <= b_zero;
            neg_q  <= op_signed & (a[XLEN-1] ^ b[XLEN-1]);
            neg_r  <= op_signed & a[XLEN-1];
            // A zero divisor keeps the raw dividend so the remainder comes back unmodified.
            q      <= (op_signed && !b_zero) ? abs_a : a;
            d      <= op_signed ? abs_b : b;
            r      <= '0;
            cnt    <= CW'(XLEN);
            busy   <= 1'b1;
`ifdef DIV_UNIT_ZERO_BYPASS_EN
            state  <= b_zero ? FIN : CALC;
`else
            state  <= CALC;
`endif
          end
        end
        CALC: begin
          done <= 1'b0;
          q    <= {q[XLEN-2:0], ~diff[XLEN]};
          r    <= diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1))
            state <= FIN;
        end
        FIN: begin
          result <= fin_val;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed vector bench for div_unit: result values, latency and the start/reset corner cases.
module tb_div_unit;

  localparam logic [4:0] DIV  = 5'b11100;
  localparam logic [4:0] DIVU = 5'b01100;
  localparam logic [4:0] REM  = 5'b00100;
  localparam logic [4:0] REMU = 5'b11000;

`ifdef DIV_UNIT_ZERO_BYPASS_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  alusel = 5'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_vec = 0;
  int n_err = 0;

  div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .alusel(alusel),
    .a(a), .b(b), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives a request through edge E0; returns with inputs scrambled, #1 after E0.
  task automatic start_op(input logic [4:0] op, input logic [31:0] va, input logic [31:0] vb);
    @(negedge clk);
    start = 1'b1; alusel = op; a = va; b = vb;
    @(posedge clk); #1;
    start = 1'b0; alusel = 5'b00000; a = $urandom; b = $urandom;
  endtask

  // Counts edges until done is seen high; lat enters as edges already elapsed since E0.
  task automatic wait_done(inout int lat);
    int guard = 0;
    while (!done && guard < 100) begin
      @(posedge clk); #1;
      lat++; guard++;
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL timeout: no done after %0d edges, required within 100", guard);
    end
  endtask

  initial begin
    int lat;
    bit seen;

    vecs[0]  = '{DIVU, 32'd100,        32'd7,          32'd14};
    vecs[1]  = '{REMU, 32'd100,        32'd7,          32'd2};
    vecs[2]  = '{DIV,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD};
    vecs[3]  = '{REM,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF};
    vecs[4]  = '{REM,  32'd7,          32'hFFFFFFFE,   32'd1};
    vecs[5]  = '{DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000};
    vecs[6]  = '{REM,  32'h80000000,   32'hFFFFFFFF,   32'd0};
    vecs[7]  = '{DIV,  32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF};
    vecs[8]  = '{REMU, 32'd5,          32'd0,          32'd5};
    vecs[9]  = '{REM,  32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB};
    vecs[10] = '{DIVU, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF};
    vecs[11] = '{DIV,  32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2};
    vecs[12] = '{REM,  32'hFFFFFF9C,   32'd7,          32'hFFFFFFFE};
    vecs[13] = '{DIVU, 32'd0,          32'd5,          32'd0};

    #3;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("v%0d_busy_e0", i), {31'b0, busy}, 32'd1);
      lat = 0;
      wait_done(lat);
      check($sformatf("v%0d_result", i), result, vecs[i].exp);
      check($sformatf("v%0d_latency", i), lat, (vecs[i].b == 0) ? ZLAT : 33);
      check($sformatf("v%0d_busy_done", i), {31'b0, busy}, 32'd0);
      @(posedge clk); #1;
      check($sformatf("v%0d_done_fall", i), {31'b0, done}, 32'd0);
      check($sformatf("v%0d_hold", i), result, vecs[i].exp);
    end

    // Invalid opcode is ignored.
    start_op(5'b00000, 32'd9, 32'd3);
    check("bad_op_busy", {31'b0, busy}, 32'd0);

    // Start while busy is ignored; start in the done cycle is taken.
    start_op(DIVU, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; alusel = DIVU; a = 32'd9; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 5;
    wait_done(lat);
    check("busy_ign_result", result, 32'd14);
    check("busy_ign_latency", lat, 33);
    start = 1'b1; alusel = DIVU; a = 32'd9; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    check("b2b_busy", {31'b0, busy}, 32'd1);
    check("b2b_done_fall", {31'b0, done}, 32'd0);
    check("b2b_hold", result, 32'd14);
    lat = 0;
    wait_done(lat);
    check("b2b_result", result, 32'd3);
    check("b2b_latency", lat, 33);

    // Asynchronous reset mid-operation.
    start_op(DIVU, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_result", result, 32'd0);
    #1 rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check("mid_rst_no_done", {31'b0, seen}, 32'd0);

    // Start accepted on the first edge after reset release.
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0; start = 1'b1; alusel = DIVU; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    check("post_rst_busy", {31'b0, busy}, 32'd1);
    lat = 0;
    wait_done(lat);
    check("post_rst_result", result, 32'd14);
    check("post_rst_latency", lat, 33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
